// File: rtl/aig_tt_sweeper.sv
// Exhaustive truth-table capture for a 4-input combinational cell (x0..x3 -> y0).
// Latency: result_valid rises 16*SETTLE_CYCLES+1 cycles after an accepted start.
// Backpressure: the result is held until result_ack; start is ignored (not queued) unless IDLE.
module aig_tt_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1  // cycles each minterm is held, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected_tt,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  input  logic        y0,
  output logic        busy,
  output logic        result_valid,
  input  logic        result_ack,
  output logic [15:0] tt_out,
  output logic        match,
  output logic [4:0]  mismatch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWEEP  = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  // Value of the settle counter on the cycle y0 is sampled.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_exp;      // expected table latched at start
  logic [15:0] r_tt;       // table being assembled
  logic [4:0]  r_cnt;      // running mismatch count
  logic [3:0]  r_idx;      // minterm currently under test
  logic [3:0]  r_settle;   // cycles the current minterm has been held
  logic [3:0]  r_x;        // minterm driven to the cell
  logic        r_busy;
  logic        r_valid;
  logic        r_match;

  // FSM strobes
  logic        w_accept;   // start taken in IDLE
  logic        w_sample;   // y0 is captured this cycle
  logic        w_last;     // sampling the final minterm
  logic        w_hold;     // sweeping, minterm still settling
  logic        w_publish;  // first RESULT cycle: present the result
  logic        w_ack_take; // consumer accepted the presented result
  logic        w_miss;     // y0 disagrees with expectation for current minterm

  assign w_miss = y0 ^ r_exp[r_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_last      = 1'b0;
    w_hold      = 1'b0;
    w_publish   = 1'b0;
    w_ack_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (r_settle == SETTLE_LAST) begin
          w_sample = 1'b1;
          if (r_idx == 4'd15) begin
            w_last      = 1'b1;
            w_state_nxt = S_RESULT;
          end
        end else begin
          w_hold = 1'b1;
        end
      end
      S_RESULT: begin
        // The final sample lands on the edge entering RESULT, so the result is
        // published one cycle later; an ack is only meaningful once valid is up.
        if (!r_valid) begin
          w_publish = 1'b1;
        end else if (result_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sweep datapath: minterm drive, table capture, mismatch accumulation, result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp    <= 16'h0000;
      r_tt     <= 16'h0000;
      r_cnt    <= 5'd0;
      r_idx    <= 4'd0;
      r_settle <= 4'd0;
      r_x      <= 4'd0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_match  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_exp    <= expected_tt;
        r_tt     <= 16'h0000;
        r_cnt    <= 5'd0;
        r_idx    <= 4'd0;
        r_settle <= 4'd0;
        r_x      <= 4'd0;
        r_busy   <= 1'b1;
        r_match  <= 1'b0;
      end
      if (w_hold) begin
        r_settle <= r_settle + 4'd1;
      end
      if (w_sample) begin
        r_tt[r_idx] <= y0;
        r_cnt       <= r_cnt + {4'd0, w_miss};
        if (w_last) begin
          // idx and x stay at 15 for the whole RESULT phase.
          r_settle <= r_settle + 4'd1;
        end else begin
          r_idx    <= r_idx + 4'd1;
          r_x      <= r_idx + 4'd1;
          r_settle <= 4'd0;
        end
      end
      if (w_publish) begin
        r_valid <= 1'b1;
        r_busy  <= 1'b0;
        r_match <= (r_cnt == 5'd0);
      end
      if (w_ack_take) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign {x3, x2, x1, x0} = r_x;
  assign busy             = r_busy;
  assign result_valid     = r_valid;
  assign tt_out           = r_tt;
  assign match            = r_match;
  assign mismatch_cnt     = r_cnt;

endmodule
